mem_stage_ctrl: RTL
===================

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning cycles to wait for dmem_ack_i before abort (legal 2..255).
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port valid_i, input, 1, EX/MEM stage content is a real instruction.
REQ-005 SHALL have port MEM_ctrl_i, input, 2, bit1 MemRead, bit0 MemWrite.
REQ-006 SHALL have port WB_ctrl_i, input, 4, write-back controls, carried through unchanged.
REQ-007 SHALL have ports alu_result_i (32, address/result), rt_data_i (32, store data), rd_index_i (5), pc_add4_i (32), all inputs.
REQ-008 SHALL have memory ports dmem_req_o (1), dmem_we_o (1), dmem_addr_o (32), dmem_wdata_o (32) as outputs, and dmem_ack_i (1), dmem_rdata_i (32) as inputs.
REQ-009 SHALL have port stall_o, output, 1, freezes PC, IF/ID, ID/EX and EX/MEM while high.
REQ-010 SHALL have MEM/WB outputs WB_ctrl_o (4), mem_data_o (32), alu_result_o (32), rd_index_o (5), pc_add4_o (32), all registered.
REQ-011 SHALL have port err_o, output, 1, sticky fault flag (misaligned, illegal ctrl, or timeout).

Function
REQ-012 SHALL implement states IDLE and BUSY.
REQ-013 Memory op = valid_i & (MEM_ctrl_i==2'b10 or 2'b01); MEM_ctrl_i==2'b11 with valid_i is illegal.
REQ-014 In IDLE, on a memory op with alu_result_i[1:0]==0, SHALL assert dmem_req_o combinationally the same cycle, with dmem_we_o=MEM_ctrl_i[0], dmem_addr_o=alu_result_i, dmem_wdata_o=rt_data_i, and enter BUSY on the next edge.
REQ-015 stall_o SHALL equal (IDLE & legal aligned memory op) | (BUSY & ~dmem_ack_i & timeout counter not expired).
REQ-016 In BUSY, dmem_req_o and its address/data/we SHALL be held stable from registered copies until the ack cycle.
REQ-017 On dmem_ack_i high in BUSY, SHALL capture dmem_rdata_i into mem_data_o (reads; writes leave mem_data_o = 0), load the other MEM/WB outputs from the held request, and return to IDLE; minimum memory-op latency 2 cycles, stall_o low in the ack cycle.
REQ-018 dmem_ack_i in IDLE SHALL be ignored.
REQ-019 Each cycle in BUSY without ack SHALL increment an 8-bit wait counter (cleared on BUSY entry); when it reaches TIMEOUT-1 without ack, SHALL set err_o, write a bubble (WB_ctrl_o=0) to MEM/WB, and return to IDLE.
REQ-020 While stall_o is high, MEM/WB SHALL receive a bubble: WB_ctrl_o=0, other outputs 0.
REQ-021 Non-memory valid instruction in IDLE: MEM/WB SHALL load inputs next edge (1-cycle latency), mem_data_o=0, no request, no stall.
REQ-022 Misaligned memory op (alu_result_i[1:0]!=0) or illegal ctrl: no request, no stall, err_o set, bubble written to MEM/WB.
REQ-023 valid_i low in IDLE: bubble written to MEM/WB.
REQ-024 err_o SHALL remain set until reset.

Reset
REQ-025 On rst_i low, immediately and regardless of clock: state=IDLE, wait counter=0, err_o=0, all MEM/WB outputs 0, held request registers 0.
REQ-026 During and right after reset, dmem_req_o and stall_o SHALL be 0 (inputs permitting); a reset in BUSY SHALL abandon the request without waiting for ack.

Verification
REQ-027 Load: MemRead, alu_result_i=0x100, ack 3 cycles after request, rdata=0xDEADBEEF -> stall_o high 3 cycles, then mem_data_o=0xDEADBEEF, rd_index_o, WB_ctrl_o passed through.
REQ-028 Store: MemWrite, addr 0x204, rt_data_i=0x12345678, ack next cycle -> dmem_we_o=1, wdata 0x12345678 held 2 cycles, mem_data_o=0, stall high 1 cycle.
REQ-029 ALU op (MEM_ctrl_i=00), alu_result_i=0x55 -> alu_result_o=0x55 one cycle later, dmem_req_o never high.
REQ-030 Load at addr 0x102 -> no request, err_o=1, WB_ctrl_o=0 next cycle; err_o still 1 after 10 cycles.
REQ-031 Load, no ack, TIMEOUT=16 -> stall_o drops after 16 stalled cycles, err_o=1, bubble in MEM/WB, state IDLE.
REQ-032 rst_i low mid-BUSY, then late ack -> outputs 0 immediately, late ack ignored, no MEM/WB update.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage controller: issues data-memory requests, stalls the upstream
// pipeline until ack or timeout, and drives the registered MEM/WB outputs.
module mem_stage_ctrl #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        valid_i,
   input  logic [1:0]  MEM_ctrl_i,
   input  logic [3:0]  WB_ctrl_i,
   input  logic [31:0] alu_result_i,
   input  logic [31:0] rt_data_i,
   input  logic [4:0]  rd_index_i,
   input  logic [31:0] pc_add4_i,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [31:0] dmem_wdata_o,
   input  logic        dmem_ack_i,
   input  logic [31:0] dmem_rdata_i,
   output logic        stall_o,
   output logic [3:0]  WB_ctrl_o,
   output logic [31:0] mem_data_o,
   output logic [31:0] alu_result_o,
   output logic [4:0]  rd_index_o,
   output logic [31:0] pc_add4_o,
   output logic        err_o
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // Last wait count before the request is abandoned.
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic        err_q, err_d;

   // Request held stable for the whole BUSY phase, together with the
   // write-back payload it will hand to MEM/WB on ack.
   logic        req_we_q, req_we_d;
   logic [31:0] req_addr_q, req_addr_d;
   logic [31:0] req_wdata_q, req_wdata_d;
   logic [3:0]  req_wb_q, req_wb_d;
   logic [4:0]  req_rd_q, req_rd_d;
   logic [31:0] req_pc_q, req_pc_d;

   logic [3:0]  wb_ctrl_q, wb_ctrl_d;
   logic [31:0] mem_data_q, mem_data_d;
   logic [31:0] alu_result_q, alu_result_d;
   logic [4:0]  rd_index_q, rd_index_d;
   logic [31:0] pc_add4_q, pc_add4_d;

   logic is_read;
   logic is_write;
   logic mem_op;
   logic illegal_op;
   logic aligned;
   logic issue;
   logic fault;
   logic expired;

   always_comb begin
      is_read    = (MEM_ctrl_i == 2'b10);
      is_write   = (MEM_ctrl_i == 2'b01);
      mem_op     = valid_i & (is_read | is_write);
      illegal_op = valid_i & (MEM_ctrl_i == 2'b11);
      aligned    = (alu_result_i[1:0] == 2'b00);
      issue      = mem_op & aligned;
      fault      = (mem_op & ~aligned) | illegal_op;
      expired    = (wait_cnt_q == WAIT_LAST);
   end

   // NOTE: every signal gets a default before the case so no path can leave
   // one unassigned and infer a latch.
   always_comb begin
      state_d      = state_q;
      wait_cnt_d   = wait_cnt_q;
      err_d        = err_q;
      req_we_d     = req_we_q;
      req_addr_d   = req_addr_q;
      req_wdata_d  = req_wdata_q;
      req_wb_d     = req_wb_q;
      req_rd_d     = req_rd_q;
      req_pc_d     = req_pc_q;

      wb_ctrl_d    = 4'h0;
      mem_data_d   = 32'h0;
      alu_result_d = 32'h0;
      rd_index_d   = 5'h0;
      pc_add4_d    = 32'h0;

      dmem_req_o   = 1'b0;
      dmem_we_o    = 1'b0;
      dmem_addr_o  = 32'h0;
      dmem_wdata_o = 32'h0;
      stall_o      = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (issue) begin
               dmem_req_o   = 1'b1;
               dmem_we_o    = MEM_ctrl_i[0];
               dmem_addr_o  = alu_result_i;
               dmem_wdata_o = rt_data_i;
               stall_o      = 1'b1;
               state_d      = BUSY;
               wait_cnt_d   = 8'h0;
               req_we_d     = MEM_ctrl_i[0];
               req_addr_d   = alu_result_i;
               req_wdata_d  = rt_data_i;
               req_wb_d     = WB_ctrl_i;
               req_rd_d     = rd_index_i;
               req_pc_d     = pc_add4_i;
            end else if (fault) begin
               err_d = 1'b1;
            end else if (valid_i) begin
               wb_ctrl_d    = WB_ctrl_i;
               alu_result_d = alu_result_i;
               rd_index_d   = rd_index_i;
               pc_add4_d    = pc_add4_i;
            end
         end

         BUSY: begin
            dmem_req_o   = 1'b1;
            dmem_we_o    = req_we_q;
            dmem_addr_o  = req_addr_q;
            dmem_wdata_o = req_wdata_q;
            if (dmem_ack_i) begin
               wb_ctrl_d    = req_wb_q;
               mem_data_d   = req_we_q ? 32'h0 : dmem_rdata_i;
               alu_result_d = req_addr_q;
               rd_index_d   = req_rd_q;
               pc_add4_d    = req_pc_q;
               state_d      = IDLE;
            end else if (expired) begin
               // Abort: stall drops this cycle so the pipeline moves on with a bubble.
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               stall_o    = 1'b1;
               wait_cnt_d = wait_cnt_q + 8'h1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops sample
   // the same pre-edge values.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q      <= IDLE;
         wait_cnt_q   <= 8'h0;
         err_q        <= 1'b0;
         req_we_q     <= 1'b0;
         req_addr_q   <= 32'h0;
         req_wdata_q  <= 32'h0;
         req_wb_q     <= 4'h0;
         req_rd_q     <= 5'h0;
         req_pc_q     <= 32'h0;
         wb_ctrl_q    <= 4'h0;
         mem_data_q   <= 32'h0;
         alu_result_q <= 32'h0;
         rd_index_q   <= 5'h0;
         pc_add4_q    <= 32'h0;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         err_q        <= err_d;
         req_we_q     <= req_we_d;
         req_addr_q   <= req_addr_d;
         req_wdata_q  <= req_wdata_d;
         req_wb_q     <= req_wb_d;
         req_rd_q     <= req_rd_d;
         req_pc_q     <= req_pc_d;
         wb_ctrl_q    <= wb_ctrl_d;
         mem_data_q   <= mem_data_d;
         alu_result_q <= alu_result_d;
         rd_index_q   <= rd_index_d;
         pc_add4_q    <= pc_add4_d;
      end
   end

   assign WB_ctrl_o    = wb_ctrl_q;
   assign mem_data_o   = mem_data_q;
   assign alu_result_o = alu_result_q;
   assign rd_index_o   = rd_index_q;
   assign pc_add4_o    = pc_add4_q;
   assign err_o        = err_q;

endmodule
